// File: rtl/alu_exec_seq.sv
// EX-stage ALU: single-cycle logic/arith ops, bit-serial multi-cycle shifts with valid/ready handshake.
// Define ALU_EXEC_BARREL_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.

`ifndef DEFAULT_ALU_CTR_BUS_WIDTH
`define DEFAULT_ALU_CTR_BUS_WIDTH 4
`endif

module alu_exec_seq #(
    parameter int unsigned DATA_BUS_WIDTH    = 32,
    parameter int unsigned ALU_CTR_BUS_WIDTH = `DEFAULT_ALU_CTR_BUS_WIDTH,
    parameter int unsigned SHAMT_BUS_WIDTH   = 5
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [ALU_CTR_BUS_WIDTH-1:0] i_alu_ctr,
    input  logic [DATA_BUS_WIDTH-1:0]    i_data_a,
    input  logic [DATA_BUS_WIDTH-1:0]    i_data_b,
    input  logic [SHAMT_BUS_WIDTH-1:0]   i_shamt,
    output logic                         o_valid,
    output logic [DATA_BUS_WIDTH-1:0]    o_result,
    output logic                         o_zero,
    output logic                         o_busy
);

    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_ADD  = ALU_CTR_BUS_WIDTH'(0);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SUB  = ALU_CTR_BUS_WIDTH'(1);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_AND  = ALU_CTR_BUS_WIDTH'(2);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_OR   = ALU_CTR_BUS_WIDTH'(3);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_XOR  = ALU_CTR_BUS_WIDTH'(4);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_NOR  = ALU_CTR_BUS_WIDTH'(5);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SLT  = ALU_CTR_BUS_WIDTH'(6);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SLL  = ALU_CTR_BUS_WIDTH'(7);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SRL  = ALU_CTR_BUS_WIDTH'(8);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SRA  = ALU_CTR_BUS_WIDTH'(9);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SLLV = ALU_CTR_BUS_WIDTH'(10);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SRLV = ALU_CTR_BUS_WIDTH'(11);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_SRAV = ALU_CTR_BUS_WIDTH'(12);
    localparam logic [ALU_CTR_BUS_WIDTH-1:0] CODE_ALU_EX_NOP  = ALU_CTR_BUS_WIDTH'(15);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SK_LL,
        SK_RL,
        SK_RA
    } shift_kind_t;

    state_t                      state, state_n;
    shift_kind_t                 kind, kind_n, op_kind;
    logic [SHAMT_BUS_WIDTH-1:0]  cnt, cnt_n, op_amt;
    logic [DATA_BUS_WIDTH-1:0]   shreg, shreg_n, step;
    logic [DATA_BUS_WIDTH-1:0]   alu_res, shift_res, op_res;
    logic [DATA_BUS_WIDTH-1:0]   result_n;
    logic                        zero_n, valid_n;
    logic                        is_shift, shift_defer, accept;

    assign accept = i_valid & o_ready & ~i_flush;

    // Opcode decode and single-cycle datapath
    always_comb begin
        is_shift = 1'b0;
        op_kind  = SK_LL;
        op_amt   = i_shamt;
        alu_res  = '0;
        case (i_alu_ctr)
            CODE_ALU_EX_ADD:  alu_res = i_data_a + i_data_b;
            CODE_ALU_EX_SUB:  alu_res = i_data_a - i_data_b;
            CODE_ALU_EX_AND:  alu_res = i_data_a & i_data_b;
            CODE_ALU_EX_OR:   alu_res = i_data_a | i_data_b;
            CODE_ALU_EX_XOR:  alu_res = i_data_a ^ i_data_b;
            CODE_ALU_EX_NOR:  alu_res = ~(i_data_a | i_data_b);
            CODE_ALU_EX_SLT:  alu_res = ($signed(i_data_a) < $signed(i_data_b)) ?
                                        DATA_BUS_WIDTH'(1) : '0;
            CODE_ALU_EX_SLL:  begin is_shift = 1'b1; op_kind = SK_LL; end
            CODE_ALU_EX_SRL:  begin is_shift = 1'b1; op_kind = SK_RL; end
            CODE_ALU_EX_SRA:  begin is_shift = 1'b1; op_kind = SK_RA; end
            CODE_ALU_EX_SLLV: begin
                is_shift = 1'b1; op_kind = SK_LL; op_amt = i_data_a[SHAMT_BUS_WIDTH-1:0];
            end
            CODE_ALU_EX_SRLV: begin
                is_shift = 1'b1; op_kind = SK_RL; op_amt = i_data_a[SHAMT_BUS_WIDTH-1:0];
            end
            CODE_ALU_EX_SRAV: begin
                is_shift = 1'b1; op_kind = SK_RA; op_amt = i_data_a[SHAMT_BUS_WIDTH-1:0];
            end
            CODE_ALU_EX_NOP:  alu_res = '0;
            default:          alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    always_comb begin
        case (op_kind)
            SK_LL:   shift_res = i_data_b << op_amt;
            SK_RL:   shift_res = i_data_b >> op_amt;
            default: shift_res = $unsigned($signed(i_data_b) >>> op_amt);
        endcase
    end
    assign shift_defer = 1'b0;
`else
    // Zero-amount shifts finish immediately with the unshifted operand
    assign shift_res   = i_data_b;
    assign shift_defer = is_shift & (op_amt != '0);
`endif

    assign op_res = is_shift ? shift_res : alu_res;

    // One bit-serial shift step
    always_comb begin
        case (kind)
            SK_LL:   step = {shreg[DATA_BUS_WIDTH-2:0], 1'b0};
            SK_RL:   step = {1'b0, shreg[DATA_BUS_WIDTH-1:1]};
            default: step = {shreg[DATA_BUS_WIDTH-1], shreg[DATA_BUS_WIDTH-1:1]};
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shreg_n  = shreg;
        kind_n   = kind;
        result_n = o_result;
        zero_n   = o_zero;
        valid_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (shift_defer) begin
                        state_n = ST_SHIFT;
                        cnt_n   = op_amt;
                        shreg_n = i_data_b;
                        kind_n  = op_kind;
                    end else begin
                        result_n = op_res;
                        zero_n   = (op_res == '0);
                        valid_n  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (i_flush) begin
                    state_n = ST_IDLE;
                end else begin
                    shreg_n = step;
                    cnt_n   = cnt - SHAMT_BUS_WIDTH'(1);
                    if (cnt == SHAMT_BUS_WIDTH'(1)) begin
                        state_n  = ST_IDLE;
                        result_n = step;
                        zero_n   = (step == '0);
                        valid_n  = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            kind     <= SK_LL;
            o_result <= '0;
            o_zero   <= 1'b1;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            kind     <= kind_n;
            o_result <= result_n;
            o_zero   <= zero_n;
            o_valid  <= valid_n;
            o_ready  <= (state_n == ST_IDLE);
            o_busy   <= (state_n == ST_SHIFT);
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed vector table plus flush/reset sequences.
// Expectations switch with ALU_EXEC_BARREL_SHIFT_EN (all shifts complete in one cycle).

module tb_alu_exec_seq;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_NOR  = 4'd5;
    localparam logic [3:0] C_SLT  = 4'd6;
    localparam logic [3:0] C_SLL  = 4'd7;
    localparam logic [3:0] C_SRL  = 4'd8;
    localparam logic [3:0] C_SRA  = 4'd9;
    localparam logic [3:0] C_SLLV = 4'd10;
    localparam logic [3:0] C_SRLV = 4'd11;
    localparam logic [3:0] C_SRAV = 4'd12;
    localparam logic [3:0] C_BAD  = 4'd13;
    localparam logic [3:0] C_NOP  = 4'd15;

`ifdef ALU_EXEC_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    localparam int NVEC = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        vld_in;
    logic        rdy;
    logic [3:0]  ctr;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        vld_out;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic        zero;
        int          lat;    // serial mode: edges from accepting edge to completion edge
    } vec_t;

    vec_t vecs[NVEC];

    alu_exec_seq dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_flush   (flush),
        .i_valid   (vld_in),
        .o_ready   (rdy),
        .i_alu_ctr (ctr),
        .i_data_a  (a),
        .i_data_b  (b),
        .i_shamt   (shamt),
        .o_valid   (vld_out),
        .o_result  (result),
        .o_zero    (zero),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic [3:0] c, input logic [31:0] va,
                                input logic [31:0] vb, input logic [4:0] sh,
                                input logic [31:0] r, input logic z, input int l);
        vec_t v;
        v.name = nm; v.code = c; v.a = va; v.b = vb; v.shamt = sh;
        v.res = r; v.zero = z; v.lat = l;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns edges until o_valid and busy samples seen meanwhile
    task automatic run_op(input logic [3:0] c, input logic [31:0] va, input logic [31:0] vb,
                          input logic [4:0] sh, output int k, output int busy_cnt);
        ctr = c; a = va; b = vb; shamt = sh; vld_in = 1'b1;
        @(posedge clk); #1;
        vld_in = 1'b0;
        k = 0;
        busy_cnt = 0;
        while (!vld_out && k < 40) begin
            if (busy && !rdy) busy_cnt++;
            @(posedge clk); #1;
            k++;
        end
    endtask

    initial begin
        int k, bc, vcnt;
        vecs[0]  = mk("add_ovf",  C_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 0);
        vecs[1]  = mk("sub_zero", C_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 0);
        vecs[2]  = mk("slt_neg",  C_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 0);
        vecs[3]  = mk("slt_pos",  C_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 0);
        vecs[4]  = mk("xor",      C_XOR,  32'hF0F0F0F0, 32'hFFFF0000, 5'd0,  32'h0F0FF0F0, 1'b0, 0);
        vecs[5]  = mk("and",      C_AND,  32'hF0F0F0F0, 32'hFFFF0000, 5'd0,  32'hF0F00000, 1'b0, 0);
        vecs[6]  = mk("or",       C_OR,   32'h0000F0F0, 32'h0F000000, 5'd0,  32'h0F00F0F0, 1'b0, 0);
        vecs[7]  = mk("nor",      C_NOR,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 0);
        vecs[8]  = mk("unknown",  C_BAD,  32'h00000005, 32'h00000003, 5'd0,  32'h00000000, 1'b1, 0);
        vecs[9]  = mk("nop",      C_NOP,  32'h00000005, 32'h00000003, 5'd0,  32'h00000000, 1'b1, 0);
        vecs[10] = mk("sra4",     C_SRA,  32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 4);
        vecs[11] = mk("srlv4",    C_SRLV, 32'hFFFFFF24, 32'hF0000000, 5'd0,  32'h0F000000, 1'b0, 4);
        vecs[12] = mk("sll31",    C_SLL,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 31);
        vecs[13] = mk("sll0",     C_SLL,  32'h00000000, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 0);
        vecs[14] = mk("srl31",    C_SRL,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 31);
        vecs[15] = mk("sllv1",    C_SLLV, 32'h00000021, 32'h80000000, 5'd7,  32'h00000000, 1'b1, 1);
        vecs[16] = mk("srav3",    C_SRAV, 32'h00000003, 32'h7FFFFFF0, 5'd0,  32'h0FFFFFFE, 1'b0, 3);
        vecs[17] = mk("sub_neg",  C_SUB,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0, 0);

        rst = 1'b0; flush = 1'b0; vld_in = 1'b0; ctr = '0; a = '0; b = '0; shamt = '0;
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  32'(rdy),     32'd1);
        check("rst_valid",  32'(vld_out), 32'd0);
        check("rst_result", result,       32'd0);
        check("rst_zero",   32'(zero),    32'd1);
        check("rst_busy",   32'(busy),    32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            int exp_lat;
            exp_lat = BARREL ? 0 : vecs[i].lat;
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].shamt, k, bc);
            check({vecs[i].name, "_lat"},    32'(k),    32'(exp_lat));
            check({vecs[i].name, "_result"}, result,    vecs[i].res);
            check({vecs[i].name, "_zero"},   32'(zero), 32'(vecs[i].zero));
            check({vecs[i].name, "_busy"},   32'(bc),   32'(exp_lat));
            check({vecs[i].name, "_ready"},  32'(rdy),  32'd1);
            @(posedge clk); #1;
            check({vecs[i].name, "_pulse"},  32'(vld_out), 32'd0);
        end

        // Flush during the second shift cycle of SLL by 10
        run_op(C_ADD, 32'd1, 32'd2, 5'd0, k, bc);
        check("pre_flush_result", result, 32'd3);
        ctr = C_SLL; a = '0; b = 32'd1; shamt = 5'd10; vld_in = 1'b1;
        @(posedge clk); #1;
        vld_in = 1'b0;
        vcnt = int'(vld_out);
        @(posedge clk); #1;
        vcnt += int'(vld_out);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vcnt += int'(vld_out);
        check("flush_busy",  32'(busy), 32'd0);
        check("flush_ready", 32'(rdy),  32'd1);
        repeat (12) begin
            @(posedge clk); #1;
            vcnt += int'(vld_out);
        end
        check("flush_valid_cnt", 32'(vcnt), BARREL ? 32'd1 : 32'd0);
        check("flush_result",    result,    BARREL ? 32'h00000400 : 32'd3);

        // Flush with valid in IDLE: nothing accepted
        run_op(C_SUB, 32'd9, 32'd2, 5'd0, k, bc);
        check("pre_idleflush_result", result, 32'd7);
        ctr = C_ADD; a = 32'd10; b = 32'd10; vld_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        vld_in = 1'b0; flush = 1'b0;
        check("idleflush_valid", 32'(vld_out), 32'd0);
        @(posedge clk); #1;
        check("idleflush_valid2", 32'(vld_out), 32'd0);
        check("idleflush_result", result,       32'd7);

        // Asynchronous reset in the middle of a long shift
        ctr = C_SLL; a = '0; b = 32'd1; shamt = 5'd20; vld_in = 1'b1;
        @(posedge clk); #1;
        vld_in = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_result", result,       32'd0);
        check("midrst_zero",   32'(zero),    32'd1);
        check("midrst_ready",  32'(rdy),     32'd1);
        check("midrst_busy",   32'(busy),    32'd0);
        check("midrst_valid",  32'(vld_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(C_ADD, 32'h00000010, 32'h00000020, 5'd0, k, bc);
        check("post_rst_lat",    32'(k), 32'd0);
        check("post_rst_result", result, 32'h00000030);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
